// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board store: cell and error encodings,
// the board state enum and a small cell-encoding helper.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_OCC    = 2'b01;
  localparam logic [1:0] ERR_RANGE  = 2'b10;
  localparam logic [1:0] ERR_STATE  = 2'b11;

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    FULL   = 2'd1,
    LOCKED = 2'd2
  } board_state_t;

  function automatic logic [1:0] player_cell(input logic player);
    return player ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/board_occupancy_tracker_if.sv
// Move handshake between the player-input logic (master) and the board store (slave).
interface board_occupancy_tracker_if #(
  parameter int N = 3
);
  localparam int IDX_W = $clog2(N*N);

  logic             move_valid;
  logic             move_player;
  logic [IDX_W-1:0] move_idx;
  logic             move_ack;
  logic             move_err;
  logic [1:0]       err_code;

  modport master (
    output move_valid, move_player, move_idx,
    input  move_ack, move_err, err_code
  );

  modport slave (
    input  move_valid, move_player, move_idx,
    output move_ack, move_err, err_code
  );
endinterface

// File: rtl/board_occupancy_tracker_cell_decoder.sv
// Maps a row-major cell index to a one-hot write enable and flags indices
// that fall past the last cell.
module cell_decoder #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N*N)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [N*N-1:0]   we,
  output logic             out_of_range
);
  localparam int CELLS = N*N;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    we           = '0;
    out_of_range = (int'(idx) >= CELLS);
    for (int k = 0; k < CELLS; k++) begin
      we[k] = (int'(idx) == k);
    end
  end

endmodule

// File: rtl/board_occupancy_tracker.sv
// Registered N x N board store: validates one move per cycle, tracks fill count
// and turn, and locks on a full board or a game-over from the win detector.
module board_occupancy_tracker
  import ttt_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N*N),
  parameter int CNT_W = $clog2(N*N+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 game_over,
  board_occupancy_tracker_if.slave mv,
  output logic [2*N*N-1:0]     board,
  output logic [CNT_W-1:0]     fill_count,
  output logic                 turn,
  output logic                 no_space
);
  localparam int CELLS = N*N;

  board_state_t     state, state_next;
  logic [CELLS-1:0] cell_we;
  logic [CELLS-1:0] occupied;
  logic             idx_oob;
  logic             cell_busy;
  logic             accept;
  logic             reject;
  logic [1:0]       code;

  cell_decoder #(.N(N), .IDX_W(IDX_W)) u_cell_decoder (
    .idx          (mv.move_idx),
    .we           (cell_we),
    .out_of_range (idx_oob)
  );

  always_comb begin
    occupied = '0;
    for (int k = 0; k < CELLS; k++) begin
      occupied[k] = (board[2*k +: 2] != CELL_EMPTY);
    end
  end

  // An out-of-range index has an all-zero enable, so it never reads as busy.
  assign cell_busy = |(occupied & cell_we);

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) state <= PLAY;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      PLAY: begin
        if (game_over)                                         state_next = LOCKED;
        else if (accept && fill_count == CNT_W'(CELLS - 1))    state_next = FULL;
      end
      FULL:    state_next = FULL;
      LOCKED:  state_next = LOCKED;
      default: state_next = PLAY;
    endcase
  end

  // Move check in priority order; result is registered below.
  always_comb begin
    accept = 1'b0;
    reject = 1'b0;
    code   = ERR_NONE;
    if (mv.move_valid) begin
      if (state != PLAY || game_over) begin
        reject = 1'b1;
        code   = ERR_STATE;
      end else if (idx_oob) begin
        reject = 1'b1;
        code   = ERR_RANGE;
      end else if (mv.move_player != turn) begin
        reject = 1'b1;
        code   = ERR_STATE;
      end else if (cell_busy) begin
        reject = 1'b1;
        code   = ERR_OCC;
      end else begin
        accept = 1'b1;
      end
    end
  end

  // NOTE: the board array is explicitly reset because clear starts a new game; it is state, not scratch storage.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      board       <= '0;
      fill_count  <= '0;
      turn        <= 1'b0;
      no_space    <= 1'b0;
      mv.move_ack <= 1'b0;
      mv.move_err <= 1'b0;
      mv.err_code <= ERR_NONE;
    end else begin
      mv.move_ack <= accept;
      mv.move_err <= reject;
      mv.err_code <= code;
      no_space    <= (state_next == FULL);
      if (accept) begin
        for (int k = 0; k < CELLS; k++) begin
          if (cell_we[k]) board[2*k +: 2] <= player_cell(mv.move_player);
        end
        fill_count <= fill_count + 1'b1;
        turn       <= ~turn;
      end
    end
  end

endmodule
